// File: rtl/dphy_pkg.sv
// dphy_pkg: shared types and constants for the D-PHY HS receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the sync-aligner FSM state type, the default HS leader/sync byte,
// and a helper that maps a detected sync offset to the first payload slice.
package dphy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2,
        FAIL   = 2'd3
    } hs_state_t;

    localparam int         SYNC_LEN          = 8;
    localparam logic [7:0] DPHY_SYNC_PATTERN = 8'hB8;

    // Start bit of a payload word inside the two-word window. When the sync
    // byte ends inside the older word the payload is already aligned in the
    // same window; otherwise it starts one word later, so the base wraps
    // back by one word width.
    function automatic int slice_base(input int k, input int data_w);
        return (k + SYNC_LEN <= data_w) ? (k + SYNC_LEN) : (k + SYNC_LEN - data_w);
    endfunction

endpackage

// File: rtl/sync_offset_encoder.sv
// sync_offset_encoder: DATA_W-to-$clog2(DATA_W) priority encoder, highest set bit wins.
// Latency: combinational.
// Backpressure: none.
//
// Ports: req   - one request bit per candidate bit offset
//        idx   - index of the highest set request bit (0 when none)
//        found - at least one request bit is set
module sync_offset_encoder #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]         req,
    output logic [$clog2(DATA_W)-1:0] idx,
    output logic                      found
);

    // Ascending scan: the last hit seen is the highest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (req[i]) begin
                idx   = ($clog2(DATA_W))'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_sync_aligner.sv
// hs_sync_aligner: hunts the D-PHY HS sync byte in a deserialised lane and emits byte-aligned payload.
// Latency: out_valid rises 2 cycles after the in_valid beat that carries the word's last bit.
// Backpressure: none; in_valid=0 cycles freeze the window and hunt counter and produce no output.
//
// Ports: clk, rst (synchronous, active-high), hs_active (lane in HS mode),
//        in_valid/in_data (raw words, bit 0 earliest on the wire),
//        out_valid/out_data (aligned payload), locked, sync_offset, sync_err (hunt timeout pulse).
// Build option: HS_SYNC_ERR_TOLERANT_EN also accepts a sync byte with exactly one bit error,
//               used only when no exact match exists in the same beat.
module hs_sync_aligner
    import dphy_pkg::*;
#(
    parameter int         DATA_W       = 8,
    parameter logic [7:0] SYNC_PATTERN = DPHY_SYNC_PATTERN,
    parameter int         MAX_HUNT     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hs_active,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      locked,
    output logic [$clog2(DATA_W)-1:0] sync_offset,
    output logic                      sync_err
);

    localparam int OFF_W = $clog2(DATA_W);
    localparam int WIN_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(MAX_HUNT + 1);
    localparam int SEL_W = $clog2(DATA_W + 1);

    hs_state_t         state;
    logic [WIN_W-1:0]  win_q;      // {newest word, previous word}
    logic              beat_q;     // win_q was updated by the last accepted beat
    logic [CNT_W-1:0]  hunt_cnt;

    logic [DATA_W-1:0] exact_hit;
    logic [OFF_W-1:0]  exact_idx;
    logic              exact_found;

    logic              hit;
    logic [OFF_W-1:0]  hit_idx;
    logic              hit_emit_now;
    logic [SEL_W-1:0]  hit_sel;
    logic [SEL_W-1:0]  lock_sel;

    always_comb begin
        exact_hit = '0;
        for (int k = 0; k < DATA_W; k++) begin
            exact_hit[k] = (win_q[k +: SYNC_LEN] == SYNC_PATTERN);
        end
    end

    sync_offset_encoder #(.DATA_W(DATA_W)) u_exact_enc (
        .req   (exact_hit),
        .idx   (exact_idx),
        .found (exact_found)
    );

`ifdef HS_SYNC_ERR_TOLERANT_EN
    logic [DATA_W-1:0] near_hit;
    logic [OFF_W-1:0]  near_idx;
    logic              near_found;

    always_comb begin
        near_hit = '0;
        for (int k = 0; k < DATA_W; k++) begin
            near_hit[k] = ($countones(win_q[k +: SYNC_LEN] ^ SYNC_PATTERN) == 1);
        end
    end

    sync_offset_encoder #(.DATA_W(DATA_W)) u_near_enc (
        .req   (near_hit),
        .idx   (near_idx),
        .found (near_found)
    );

    // An exact hit anywhere in the beat outranks every one-bit-error hit.
    assign hit     = exact_found | near_found;
    assign hit_idx = exact_found ? exact_idx : near_idx;
`else
    assign hit     = exact_found;
    assign hit_idx = exact_idx;
`endif

    // Payload word 0 is complete in the matching window only when the sync
    // byte ends inside the older word; otherwise it waits for the next beat.
    assign hit_emit_now = (int'(hit_idx) + SYNC_LEN <= DATA_W);
    assign hit_sel      = SEL_W'(slice_base(int'(hit_idx), DATA_W));
    assign lock_sel     = SEL_W'(slice_base(int'(sync_offset), DATA_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            win_q       <= '0;
            beat_q      <= 1'b0;
            hunt_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            locked      <= 1'b0;
            sync_offset <= '0;
            sync_err    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (!hs_active) begin
                // Leaving HS: flush everything, including a beat still in flight.
                state    <= IDLE;
                win_q    <= '0;
                beat_q   <= 1'b0;
                hunt_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                beat_q <= 1'b0;
                if (in_valid && state != FAIL) begin
                    win_q  <= {in_data, win_q[WIN_W-1 -: DATA_W]};
                    beat_q <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        state    <= HUNT;
                        hunt_cnt <= '0;
                    end
                    HUNT: begin
                        if (beat_q) begin
                            if (hit) begin
                                state       <= LOCKED;
                                sync_offset <= hit_idx;
                                locked      <= 1'b1;
                                if (hit_emit_now) begin
                                    out_valid <= 1'b1;
                                    out_data  <= win_q[hit_sel +: DATA_W];
                                end
                            end else if (hunt_cnt == CNT_W'(MAX_HUNT - 1)) begin
                                state    <= FAIL;
                                sync_err <= 1'b1;
                            end else begin
                                hunt_cnt <= hunt_cnt + CNT_W'(1);
                            end
                        end
                    end
                    LOCKED: begin
                        if (beat_q) begin
                            out_valid <= 1'b1;
                            out_data  <= win_q[lock_sel +: DATA_W];
                        end
                    end
                    default: begin
                        // FAIL: input is discarded until hs_active drops.
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hs_sync_aligner.md
HS_SYNC_ALIGNER -- requirements
Module: hs_sync_aligner

Interface
REQ-001 SHALL have parameter DATA_W, default 8, deserialised lane word width; legal values 8 or 16.
REQ-002 SHALL have parameter SYNC_PATTERN, default 8'hB8, the D-PHY HS leader/sync byte (SYNC_LEN = 8).
REQ-003 SHALL have parameter MAX_HUNT, default 32, the number of valid words searched before the hunt is declared failed.
REQ-004 SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 hs_active  in  1  lane is in HS mode; low = LP/idle.
REQ-008 in_valid  in  1  in_data carries a new word this cycle.
REQ-009 in_data  in  DATA_W  raw word; bit 0 is the earliest bit on the wire.
REQ-010 out_valid  out  1  out_data holds an aligned payload word.
REQ-011 out_data  out  DATA_W  byte-aligned payload word.
REQ-012 locked  out  1  sync was found; alignment is held.
REQ-013 sync_offset  out  $clog2(DATA_W)  bit offset of the detected sync.
REQ-014 sync_err  out  1  one-cycle pulse on hunt timeout.

Function
REQ-015 SHALL implement FSM states IDLE, HUNT, LOCKED, FAIL.
REQ-016 IDLE -> HUNT when hs_active=1; any state -> IDLE, with the search window flushed, on the cycle after hs_active=0.
REQ-017 In HUNT, each in_valid beat SHALL form window W = {in_data, previous valid word} and test W[k +: 8] == SYNC_PATTERN for every k in 0..DATA_W-1.
REQ-018 On multiple matches, the highest k SHALL win, selected by the priority encoder.
REQ-019 On a match: HUNT -> LOCKED; sync_offset latches k; locked=1 from the next cycle.
REQ-020 In LOCKED, output word n SHALL be stream bits [k+8+n*DATA_W +: DATA_W]; out_valid SHALL rise exactly 2 cycles after the in_valid beat that supplies the word's last bit.
REQ-021 in_valid=0 cycles SHALL freeze the window and the hunt counter; no out_valid is generated for them.
REQ-022 The hunt counter counts valid words in HUNT; reaching MAX_HUNT without a match -> FAIL with sync_err=1 for exactly one cycle.
REQ-023 FAIL SHALL discard input until hs_active=0.
REQ-024 The sync byte itself SHALL never appear on out_data.
REQ-025 When hs_active falls and in_valid=1 in the same cycle, that word SHALL be dropped.

Reset
REQ-026 rst=1 SHALL force IDLE, out_valid=0, out_data=0, locked=0, sync_offset=0, sync_err=0, with the window and counter cleared; this applies from any state, including mid-LOCKED.

Configuration
REQ-027 When HS_SYNC_ERR_TOLERANT_EN is defined, a k whose window slice differs from SYNC_PATTERN in exactly one bit SHALL be accepted, but only if no exact match exists in the same beat; exact matches keep priority.
REQ-028 When HS_SYNC_ERR_TOLERANT_EN is undefined, only exact matches SHALL be accepted and the tolerance logic SHALL be absent.

Structure
REQ-029 The shared package dphy_pkg SHALL hold the FSM state enum typedef and the default SYNC_PATTERN constant.
REQ-030 Sub-module sync_offset_encoder SHALL be a parametrised DATA_W-to-$clog2(DATA_W) priority encoder (highest set bit wins) with a found flag.

Verification (DATA_W=8, MAX_HUNT=4 unless noted)
REQ-031 hs_active=1; words 0x00, 0xB8, 0x55 -> locked, sync_offset=0, first out_data=0x55.
REQ-032 Words 0x00, 0xC0, 0x05, 0x07 -> sync_offset=3, first out_data=0xE0, out_valid 2 cycles after the 0x07 beat.
REQ-033 Five words of 0x00 -> sync_err high for exactly one cycle after the 4th; later 0xB8 is ignored until hs_active toggles.
REQ-034 Words 0x00, 0xB9, 0x55 -> lock at offset 0 with HS_SYNC_ERR_TOLERANT_EN defined; remains in HUNT without it.
REQ-035 LOCKED streaming, rst=1 for one cycle -> all outputs 0 next cycle; in_valid gaps inserted mid-stream -> payload order and values unchanged.
REQ-036 DATA_W=16: sync at offset 13 spanning two words -> sync_offset=13, payload correct across the word boundary.
